// File: rtl/box_poll_master.sv
// box_poll_master: Avalon-MM master that polls a PIO edge-capture register and queues {edge_mask, data} events; define BOX_POLL_TIMESTAMP_EN to add per-event cycle timestamps (evt_ts)
module box_poll_master #(
  parameter int POLL_PERIOD = 1000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [31:0] evt_data,
`ifdef BOX_POLL_TIMESTAMP_EN
  output logic [31:0] evt_ts,
`endif
  output logic [6:0]  fifo_level,
  output logic [15:0] drop_count
);
  localparam logic [23:0] LAST = 24'(POLL_PERIOD - 1);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef BOX_POLL_TIMESTAMP_EN
  localparam int W = 64;
`else
  localparam int W = 32;
`endif
  typedef enum logic [2:0] {IDLE, RD_EDGE, WT_EDGE, RD_DATA, WT_DATA, CLR, PUSH} state_t;
  state_t state;
  logic [23:0] timer;
  logic [15:0] edge_mask, data;
  logic to_idle, full, push, pop;
  logic [W-1:0] mem [FIFO_DEPTH];
  logic [W-1:0] entry, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic unused_hi;
  assign unused_hi = ^avm_readdata[31:16];
  assign avm_writedata = 32'hFFFF_FFFF;
  assign to_idle = state == PUSH || (state == WT_EDGE && avm_readdatavalid && avm_readdata[15:0] == '0);
  assign full = fifo_level == 7'(FIFO_DEPTH);
  assign push = state == PUSH && !full;
  assign pop = evt_valid && evt_ready;
  assign evt_valid = fifo_level != '0;
  assign head = mem[rd_ptr];
  assign evt_data = head[31:0];
`ifdef BOX_POLL_TIMESTAMP_EN
  logic [31:0] ts, ts_cap;
  assign evt_ts = head[63:32];
  assign entry = {ts_cap, edge_mask, data};
  // Free-running cycle counter, sampled when the edge-capture read returns
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ts <= '0;
      ts_cap <= '0;
    end else begin
      ts <= ts + 32'd1;
      if (state == WT_EDGE && avm_readdatavalid) ts_cap <= ts;
    end
`else
  assign entry = {edge_mask, data};
`endif
  // Poll timer: runs while enabled, parks at LAST when a poll is overdue, restarts at each poll and on a late return to IDLE
  always_ff @(posedge clk or posedge reset)
    if (reset) timer <= '0;
    else timer <= (!enable || (timer == LAST && (state == IDLE || to_idle))) ? '0 : timer + 24'(timer != LAST);
  // Poll sequencer with registered Avalon command outputs held until accepted
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      avm_address <= '0;
      avm_read <= 1'b0;
      avm_write <= 1'b0;
      edge_mask <= '0;
      data <= '0;
      drop_count <= '0;
    end else begin
      case (state)
        IDLE: if (enable && timer == LAST) begin
          state <= RD_EDGE;
          avm_address <= 2'd3;
          avm_read <= 1'b1;
        end
        RD_EDGE: if (!avm_waitrequest) begin
          state <= WT_EDGE;
          avm_read <= 1'b0;
        end
        WT_EDGE: if (avm_readdatavalid) begin
          edge_mask <= avm_readdata[15:0];
          if (avm_readdata[15:0] != '0) begin
            state <= RD_DATA;
            avm_address <= 2'd0;
            avm_read <= 1'b1;
          end else state <= IDLE;
        end
        RD_DATA: if (!avm_waitrequest) begin
          state <= WT_DATA;
          avm_read <= 1'b0;
        end
        WT_DATA: if (avm_readdatavalid) begin
          data <= avm_readdata[15:0];
          state <= CLR;
          avm_address <= 2'd3;
          avm_write <= 1'b1;
        end
        CLR: if (!avm_waitrequest) begin
          state <= PUSH;
          avm_write <= 1'b0;
        end
        PUSH: begin
          state <= IDLE;
          if (full && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  // Show-ahead event FIFO; fullness is judged before any same-cycle pop
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= entry;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + 7'(push) - 7'(pop);
    end
endmodule

// File: tb/tb_box_poll_master.sv
// tb_box_poll_master: randomized Avalon PIO slave plus queue-based event scoreboard for box_poll_master
`timescale 1ns/1ps
module tb_box_poll_master;
  localparam int P = 10;
  localparam int D = 4;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0;
  logic [1:0] avm_address;
  logic avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = '0;
  logic avm_waitrequest = 1'b0, avm_readdatavalid = 1'b0;
  logic evt_valid;
  logic evt_ready = 1'b0;
  logic [31:0] evt_data;
  logic [6:0] fifo_level;
  logic [15:0] drop_count;
`ifdef BOX_POLL_TIMESTAMP_EN
  logic [31:0] evt_ts;
`endif

  box_poll_master #(.POLL_PERIOD(P), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
`ifdef BOX_POLL_TIMESTAMP_EN
    .evt_ts(evt_ts),
`endif
    .fifo_level(fifo_level), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0, n_err = 0;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // PIO contents and slave timing knobs
  logic [15:0] edge_reg = '0, data_reg = '0;
  int ws_lo = 0, ws_hi = 0, lat_lo = 1, lat_hi = 1;
  int n_wr = 0, n_rd0 = 0, n_rd3 = 0;

  // Reference model: expected FIFO contents, drop counter, events awaiting their PUSH cycle
  typedef struct { int at; logic [31:0] v; } pend_t;
  logic [31:0] exp_q[$];
  pend_t pend_q[$];
  int exp_drop = 0;

  // Slave bookkeeping
  int stall_left = 0, rdv_cnt = 0, s_last = 0, r_last = 0, exp_next = 0;
  logic [1:0] rd_addr = '0, p_addr = '0;
  bit cmd_open = 0, have_last = 0, en_cont = 0, rd_pend = 0;
  logic p_rd = 0, p_wr = 0, p_wait = 0, p_en = 0;
  logic [15:0] m_lat = '0, d_lat = '0;

  // Slave drive: waitrequest per command, read data after the chosen latency
  always @(posedge clk) begin
    #1;
    if (reset) begin
      cmd_open = 0; stall_left = 0; rdv_cnt = 0; rd_pend = 0; exp_next = 0;
      have_last = 0; en_cont = 0;
      avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
    end else begin
      if (avm_read || avm_write) begin
        if (!cmd_open) begin
          cmd_open = 1;
          stall_left = $urandom_range(ws_hi, ws_lo);
        end
        avm_waitrequest = stall_left != 0;
        if (stall_left != 0) stall_left--;
      end else avm_waitrequest = 1'($urandom_range(1, 0));
      avm_readdatavalid = 1'b0;
      avm_readdata = {16'($urandom), 16'($urandom)};
      if (rdv_cnt != 0) begin
        rdv_cnt--;
        if (rdv_cnt == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata[15:0] = (rd_addr == 2'd3) ? edge_reg : data_reg;
        end
      end
    end
  end

  // Slave observe: protocol order, stability under stall, poll spacing, acceptance
  always @(negedge clk) begin : slave_mon
    bit start;
    if (reset) begin
      p_rd = 0; p_wr = 0; p_wait = 0; p_en = 0;
    end else begin
      start = (avm_read || avm_write) && !(p_wait && (p_rd || p_wr));
      if ((p_rd || p_wr) && p_wait)
        check("stall_hold", {28'b0, avm_read, avm_write, avm_address}, {28'b0, p_rd, p_wr, p_addr});
      if (avm_read || avm_write) check("rd_wr_exclusive", 32'(avm_read & avm_write), 32'd0);
      if (start) begin
        check("cmd_while_read_pending", 32'(rd_pend), 32'd0);
        check("cmd_order", {28'b0, avm_read, avm_write, avm_address},
              exp_next == 0 ? 32'hB : exp_next == 1 ? 32'h8 : 32'h7);
        if (avm_write) check("writedata", avm_writedata, 32'hFFFF_FFFF);
        if (avm_read && avm_address == 2'd3) begin
          n_rd3++;
          check("poll_while_disabled", 32'(p_en), 32'd1);
          if (have_last && en_cont)
            check("poll_spacing", 32'(cyc), 32'((r_last <= s_last + P - 1) ? s_last + P : r_last + P));
          have_last = 1; en_cont = 1; s_last = cyc;
        end
      end
      if (avm_readdatavalid && rd_pend) begin
        rd_pend = 0;
        if (rd_addr == 2'd3) begin
          m_lat = avm_readdata[15:0];
          exp_next = (m_lat != 0) ? 1 : 0;
          if (m_lat == 0) r_last = cyc + 1;
        end else begin
          d_lat = avm_readdata[15:0];
          exp_next = 2;
        end
      end
      if ((avm_read || avm_write) && !avm_waitrequest) begin
        cmd_open = 0;
        if (avm_read) begin
          rd_pend = 1; rd_addr = avm_address;
          rdv_cnt = $urandom_range(lat_hi, lat_lo);
          if (avm_address == 2'd0) n_rd0++;
        end else begin
          n_wr++;
          edge_reg = '0;
          exp_next = 0;
          r_last = cyc + 2;
          pend_q.push_back('{cyc + 1, {m_lat, d_lat}});
        end
      end
      if (!enable) en_cont = 0;
      p_rd = avm_read; p_wr = avm_write; p_addr = avm_address; p_wait = avm_waitrequest; p_en = enable;
    end
  end

  // Scoreboard: compare stream state, then apply this cycle's pop and push/drop
  always @(negedge clk) begin : scoreboard
    bit full;
    if (!reset) begin
      check("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
      check("evt_valid", 32'(evt_valid), 32'(exp_q.size() != 0));
      check("drop_count", 32'(drop_count), 32'(exp_drop));
      if (exp_q.size() != 0) check("evt_data", evt_data, exp_q[0]);
      full = exp_q.size() == D;
      if (evt_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      while (pend_q.size() != 0 && pend_q[0].at <= cyc) begin
        if (pend_q[0].at == cyc) begin
          if (full) begin
            if (exp_drop < 65535) exp_drop++;
          end else exp_q.push_back(pend_q[0].v);
        end
        void'(pend_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, k0, k1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_read", 32'(avm_read), 32'd0);
    check("rst_write", 32'(avm_write), 32'd0);
    check("rst_address", 32'(avm_address), 32'd0);
    check("rst_writedata", avm_writedata, 32'hFFFF_FFFF);
    check("rst_evt_valid", 32'(evt_valid), 32'd0);
    check("rst_evt_data", evt_data, 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b1;
    evt_ready = 1'b1;
    // quiet PIO
    repeat (65) @(posedge clk);
    #1;
    check("quiet_poll_count", 32'(n_rd3), 32'd6);
    check("quiet_no_write", 32'(n_wr), 32'd0);
    // single event
    evt_ready = 1'b0;
    data_reg = 16'h1234;
    edge_reg = 16'h0004;
    t = 0;
    while (fifo_level != 7'd1 && t < 200) begin @(posedge clk); #1; t++; end
    check("single_level", 32'(fifo_level), 32'd1);
    check("single_data", evt_data, 32'h0004_1234);
    check("single_writes", 32'(n_wr), 32'd1);
    evt_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    // stalls
    ws_lo = 5; ws_hi = 5; lat_lo = 3; lat_hi = 3;
    data_reg = 16'hBEEF;
    edge_reg = 16'h8001;
    t = 0;
    while (n_wr != 2 && t < 300) begin @(posedge clk); #1; t++; end
    check("stall_writes", 32'(n_wr), 32'd2);
    repeat (5) @(posedge clk);
    #1;
    // overflow
    ws_lo = 0; ws_hi = 2; lat_lo = 1; lat_hi = 2;
    t = 0;
    while (fifo_level != 0 && t < 50) begin @(posedge clk); #1; t++; end
    evt_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      edge_reg = 16'($urandom_range(65535, 1));
      data_reg = 16'($urandom);
      k0 = n_wr; t = 0;
      while (n_wr == k0 && t < 300) begin @(posedge clk); #1; t++; end
      check("overflow_event_done", 32'(n_wr), 32'(k0 + 1));
    end
    repeat (3) @(posedge clk);
    #1;
    check("overflow_level", 32'(fifo_level), 32'd4);
    check("overflow_drops", 32'(drop_count), 32'd2);
    evt_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    // enable dropped during WT_DATA
    edge_reg = 16'h0F00;
    data_reg = 16'h5A5A;
    k0 = n_rd0; t = 0;
    while (n_rd0 == k0 && t < 300) begin @(posedge clk); #1; t++; end
    enable = 1'b0;
    k0 = n_wr; t = 0;
    while (n_wr == k0 && t < 300) begin @(posedge clk); #1; t++; end
    check("disable_completes_clr", 32'(n_wr), 32'(k0 + 1));
    k1 = n_rd3;
    repeat (40) @(posedge clk);
    #1;
    check("disable_no_poll", 32'(n_rd3), 32'(k1));
    enable = 1'b1;
    // randomized traffic
    ws_lo = 0; ws_hi = 3; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      evt_ready = $urandom_range(3, 0) != 0;
      if ($urandom_range(15, 0) == 0) edge_reg = edge_reg | 16'($urandom);
      if ($urandom_range(3, 0) == 0) data_reg = 16'($urandom);
      if ($urandom_range(199, 0) == 0) enable = ~enable;
    end
    // reset during CLR
    enable = 1'b1;
    evt_ready = 1'b1;
    ws_lo = 2; ws_hi = 2; lat_lo = 1; lat_hi = 1;
    edge_reg = 16'h0010;
    t = 0;
    @(negedge clk);
    while (!avm_write && t < 400) begin @(negedge clk); t++; end
    check("clr_reached", 32'(avm_write), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_async_write", 32'(avm_write), 32'd0);
    check("rst_async_read", 32'(avm_read), 32'd0);
    check("rst_async_address", 32'(avm_address), 32'd0);
    exp_q.delete();
    pend_q.delete();
    exp_drop = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_evt_valid", 32'(evt_valid), 32'd0);
    check("post_rst_drop_count", 32'(drop_count), 32'd0);
    repeat (60) @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("final_drained", 32'(exp_q.size() + pend_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
